// File: rtl/line_window_buffer.sv
// line_window_buffer
//   Sliding KSIZE x KSIZE neighbourhood generator for a raster grayscale
//   pixel stream. KSIZE-1 line buffers hold the previous lines; every accepted
//   pixel yields one new window column, and the window is flagged valid only
//   when all KSIZE x KSIZE samples belong to the current frame and line.
//
// Ports
//   clock      rising-edge system clock
//   reset      synchronous, active-high
//   in_valid   pixel accepted on any edge where high
//   in_sof     with in_valid: accepted pixel is (x=0, y=0)
//   indata     pixel value (DW bits)
//   window     flattened neighbourhood; top-left (oldest) at the MSB,
//              bottom-right (newest) at bits DW-1:0
//   win_valid  one-cycle pulse per complete interior neighbourhood
//   win_x      column of the window centre pixel
//   win_y      row of the window centre pixel
module line_window_buffer #(
    parameter int COLS  = 640,
    parameter int ROWS  = 480,
    parameter int KSIZE = 5,
    parameter int DW    = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [DW-1:0]               indata,
    output logic [KSIZE*KSIZE*DW-1:0]   window,
    output logic                        win_valid,
    output logic [10:0]                 win_x,
    output logic [9:0]                  win_y
);

    localparam int NLB = KSIZE - 1;
    localparam int H   = (KSIZE - 1) / 2;
    localparam int AW  = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [10:0] COL_LAST = 11'(COLS - 1);
    localparam logic [9:0]  ROW_LAST = 10'(ROWS - 1);
    localparam logic [10:0] KM1_X    = 11'(KSIZE - 1);
    localparam logic [9:0]  KM1_Y    = 10'(KSIZE - 1);
    localparam logic [10:0] H_X      = 11'(H);
    localparam logic [9:0]  H_Y      = 10'(H);

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [10:0] col_q, col_d, pos_col;
    logic [9:0]  row_q, row_d, pos_row;

    always_comb begin
        pos_col = in_sof ? 11'd0 : col_q;
        pos_row = in_sof ? 10'd0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (pos_col == COL_LAST) begin
                col_d = 11'd0;
                row_d = (pos_row == ROW_LAST) ? 10'd0 : pos_row + 10'd1;
            end else begin
                col_d = pos_col + 11'd1;
                row_d = pos_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: pixel and position of the accepted sample
    // ------------------------------------------------------------------
    logic          s1_valid_q;
    logic [10:0]   s1_col_q, s1_col_d;
    logic [9:0]    s1_row_q, s1_row_d;
    logic [DW-1:0] s1_pix_q, s1_pix_d;

    always_comb begin
        s1_col_d = s1_col_q;
        s1_row_d = s1_row_q;
        s1_pix_d = s1_pix_q;
        if (in_valid) begin
            s1_col_d = pos_col;
            s1_row_d = pos_row;
            s1_pix_d = indata;
        end
    end

    always_ff @(posedge clock) begin
        s1_col_q <= s1_col_d;
        s1_row_q <= s1_row_d;
        s1_pix_q <= s1_pix_d;
    end

    // ------------------------------------------------------------------
    // Line buffers. Reads are registered (block-RAM friendly), so the
    // shift-down write of a column is issued one cycle later from stage 1.
    // If the next accept reads the very column being written on that edge,
    // the pending write data is forwarded instead of the stale RAM word,
    // which preserves read-before-write ordering between accepts.
    // ------------------------------------------------------------------
    logic [DW-1:0] col_rd     [NLB];   // old lb[j][c] for the stage-1 pixel
    logic [DW-1:0] wr_data    [NLB];   // new lb[j][c] for the stage-1 pixel
    logic [DW-1:0] byp_data_q [NLB];
    logic          byp_q, byp_d;

    assign byp_d = s1_valid_q && (s1_col_q == pos_col);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NLB; gi++) begin : gen_lb
            logic [DW-1:0] lb_mem [COLS];
            logic [DW-1:0] rd_q;

            always_ff @(posedge clock) begin
                if (s1_valid_q) begin
                    lb_mem[s1_col_q[AW-1:0]] <= wr_data[gi];
                end
                rd_q <= lb_mem[pos_col[AW-1:0]];
            end

            assign col_rd[gi] = byp_q ? byp_data_q[gi] : rd_q;

            if (gi == 0) begin : gen_newest
                assign wr_data[gi] = s1_pix_q;
            end else begin : gen_older
                assign wr_data[gi] = col_rd[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        byp_q <= byp_d;
        for (int i = 0; i < NLB; i++) begin
            byp_data_q[i] <= wr_data[i];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: window shift register, indexed [row][col], row 0 = oldest
    // ------------------------------------------------------------------
    logic [DW-1:0] win_q [KSIZE][KSIZE];
    logic [DW-1:0] win_d [KSIZE][KSIZE];
    logic          win_valid_q, win_valid_d;
    logic [10:0]   win_x_q, win_x_d;
    logic [9:0]    win_y_q, win_y_d;

    always_comb begin
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        if (s1_valid_q) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            // Rightmost column: oldest line on top, incoming pixel at bottom.
            for (int i = 0; i < KSIZE - 1; i++) begin
                win_d[i][KSIZE-1] = col_rd[KSIZE-2-i];
            end
            win_d[KSIZE-1][KSIZE-1] = s1_pix_q;
            // Requiring col >= K-1 also rejects windows straddling a line wrap;
            // row >= K-1 guarantees every buffered line belongs to this frame.
            win_valid_d = (s1_row_q >= KM1_Y) && (s1_col_q >= KM1_X);
            win_x_d     = s1_col_q - H_X;
            win_y_d     = s1_row_q - H_Y;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= 11'd0;
            row_q       <= 10'd0;
            s1_valid_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_x_q     <= 11'd0;
            win_y_q     <= 10'd0;
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= in_valid;
            win_valid_q <= win_valid_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            win_q       <= win_d;
        end
    end

    // ------------------------------------------------------------------
    // Output flattening
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < KSIZE; gi++) begin : gen_row
            for (gj = 0; gj < KSIZE; gj++) begin : gen_col
                assign window[((KSIZE-1-gi)*KSIZE + (KSIZE-1-gj))*DW +: DW] = win_q[gi][gj];
            end
        end
    endgenerate

    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;

endmodule
